// File: rtl/mult32_seq.sv
// mult32_seq -- sequential 32x32 radix-2 shift-and-add multiplier.
//
// Forms the 64-bit product of A and B one partial-product step per clock and
// returns it on HI/LO. Operands are converted to magnitudes on entry; the sign
// is applied once at the end.
//
// Handshake: START is sampled only in IDLE. A, B and SIGNED are captured on that
// same edge. BUSY stays high from the following cycle until the result is
// written. DONE pulses for one cycle, and in that cycle HI/LO hold the new
// product. BUSY is low in the DONE cycle, so a START presented there is accepted
// and gives back-to-back operation. START is ignored while BUSY is high.
//
// Ports:
//   CLK        clock, rising edge active
//   RST        synchronous active-high reset (aborts any operation)
//   START      request a multiply (sampled in IDLE only)
//   SIGNED     1 = two's-complement operands, 0 = unsigned
//   A, B       multiplicand / multiplier
//   BUSY       multiply in progress
//   DONE       one-cycle pulse, new result on HI/LO
//   HI, LO     product bits [63:32] / [31:0], held until the next result
//   dbg_state  current FSM state (0 = IDLE, 1 = CALC, 2 = FIX)
module mult32_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic [1:0]            dbg_state
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [2*W:0]   acc;
    logic [W-1:0]   mcand;
    logic [5:0]     cnt;
    logic           neg;

    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     sum;
    logic [2*W:0]   acc_step;
    logic [2*W-1:0] prod;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (START) state_next = S_CALC;
            S_CALC: if (cnt == 6'(W - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign BUSY      = (state != S_IDLE);
    assign dbg_state = state;

    // Magnitudes stay W-bit unsigned, so the most negative value maps onto
    // itself (0x8000_0000) and is still correct as an unsigned magnitude.
    always_comb begin
        mag_a = (SIGNED && A[W-1]) ? (~A + W'(1)) : A;
        mag_b = (SIGNED && B[W-1]) ? (~B + W'(1)) : B;
    end

    // One radix-2 step: conditional add into the upper half (carry lands in the
    // extra top bit), then a logical right shift of the whole accumulator.
    // acc[2W] is always zero after a shift, so folding it into the add only
    // keeps the carry path uniform.
    always_comb begin
        sum      = {acc[2*W], acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        acc_step = {1'b0, sum, acc[W-1:1]};
        prod     = neg ? (~acc[2*W-1:0] + (2*W)'(1)) : acc[2*W-1:0];
    end

    // Datapath and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        mcand <= mag_a;
                        acc   <= {{(W+1){1'b0}}, mag_b};
                        cnt   <= '0;
                        neg   <= SIGNED & (A[W-1] ^ B[W-1]);
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 6'd1;
                end
                S_FIX: begin
                    HI   <= prod[2*W-1:W];
                    LO   <= prod[W-1:0];
                    DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32_seq.sv
// Testbench for mult32_seq: directed sequence with a scoreboard queue of
// expected 64-bit products, checked when DONE pulses.
module tb_mult32_seq;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        SIGNED;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    int          checks;
    int          errors;

    mult32_seq #(.DATA_WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .SIGNED    (SIGNED),
        .A         (A),
        .B         (B),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .HI        (HI),
        .LO        (LO),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns 1ns after edge 0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input bit push);
        A      = a;
        B      = b;
        SIGNED = s;
        START  = 1'b1;
        if (push) exp_q.push_back(model_mul(a, b, s));
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Waits for DONE (bounded), checks latency, BUSY, and the scoreboard entry.
    task automatic wait_done(input string tag, input int elapsed);
        int          cyc;
        bit          seen;
        logic [63:0] exp;
        cyc  = elapsed;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (DONE === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_at_done"}, {63'd0, BUSY}, 64'd0);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_product"}, {HI, LO}, exp);
        end else begin
            check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] held;
        bit          changed;
        int          pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        checks = 0;
        errors = 0;
        RST    = 1'b1;
        START  = 1'b0;
        SIGNED = 1'b0;
        A      = '0;
        B      = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_hilo",  {HI, LO}, 64'd0);
        check("rst_busy",  {63'd0, BUSY}, 64'd0);
        check("rst_done",  {63'd0, DONE}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);
        RST = 1'b0;

        // Idle with START low: nothing should move.
        changed = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (BUSY !== 1'b0 || DONE !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) changed = 1'b1;
        end
        check("idle_no_change", {63'd0, changed}, 64'd0);

        // Unsigned 0xFFFF_FFFF * 2
        start_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        check("busy_after_start", {63'd0, BUSY}, 64'd1);
        wait_done("u_ffff_x2", 0);
        check("u_ffff_x2_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        held = {HI, LO};
        @(posedge CLK);
        #1;
        check("done_one_cycle", {63'd0, DONE}, 64'd0);
        check("result_held", {HI, LO}, held);

        // Signed -1 * 2
        start_op(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
        wait_done("s_m1_x2", 0);
        check("s_m1_x2_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);

        // Most negative squared, signed then unsigned
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done("s_min_sq", 0);
        check("s_min_sq_const", {HI, LO}, 64'h4000_0000_0000_0000);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        wait_done("u_min_sq", 0);
        check("u_min_sq_const", {HI, LO}, 64'h4000_0000_0000_0000);

        // Mixed-sign signed operands
        start_op(32'h0000_0003, 32'hFFFF_FFF9, 1'b1, 1'b1);
        wait_done("s_3_xm7", 0);
        check("s_3_xm7_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Unsigned with a START pulse mid-CALC that must be ignored
        held = {HI, LO};
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        repeat (10) begin
            @(posedge CLK);
            #1;
        end
        check("hilo_stable_in_calc", {HI, LO}, held);
        start_op(32'h0000_0005, 32'h0000_0009, 1'b1, 1'b0);
        A = 32'hFFFF_0000;
        B = 32'h0000_FFFF;
        wait_done("u_big_ignore_start", 11);
        check("u_big_const", {HI, LO}, 64'h0B00_EA4E_242D_2080);

        // Back-to-back: START in the DONE cycle
        start_op(32'd7, 32'd6, 1'b0, 1'b1);
        check("b2b_busy_again", {63'd0, BUSY}, 64'd1);
        check("b2b_done_dropped", {63'd0, DONE}, 64'd0);
        wait_done("b2b_7x6", 0);
        check("b2b_7x6_const", {HI, LO}, 64'd42);

        // Random back-to-back operations against the model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = $urandom();
            rs = 1'($urandom_range(0, 1));
            start_op(ra, rb, rs, 1'b1);
            wait_done("rand_op", 0);
        end

        // Reset in the middle of CALC
        @(posedge CLK);
        #1;
        start_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b0);
        repeat (15) begin
            @(posedge CLK);
            #1;
        end
        RST   = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        START = 1'b0;
        check("midrst_busy",  {63'd0, BUSY}, 64'd0);
        check("midrst_hilo",  {HI, LO}, 64'd0);
        check("midrst_done",  {63'd0, DONE}, 64'd0);
        check("midrst_state", {62'd0, dbg_state}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);

        // Recovery after reset
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("post_rst", 0);
        check("post_rst_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
